// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready synchronous FIFO stage; optional first-word fall-through under STREAM_FIFO_BYPASS_EN
module stream_fifo #(
    parameter type T     = int,
    parameter int  DEPTH = 4,
    parameter int  AFULL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$bits(T)-1:0]        in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$bits(T)-1:0]        out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       afull,
    output logic                       ovf
);

    localparam int DW = $bits(T);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Port-side status and head word, all derived from registered state
    // (plus the input word itself when fall-through is enabled).
    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q != CW'(DEPTH));
        afull    = (count_q >= CW'(AFULL));
        count    = count_q;
        ovf      = ovf_q;
`ifdef STREAM_FIFO_BYPASS_EN
        // An empty FIFO presents the incoming word directly; if the consumer
        // takes it in the same cycle it never touches storage.
        bypass    = empty && in_valid && out_ready;
        out_valid = !empty || in_valid;
        out_data  = empty ? in_data : mem_q[rd_ptr_q];
`else
        bypass    = 1'b0;
        out_valid = !empty;
        out_data  = mem_q[rd_ptr_q];
`endif
    end

    // Handshake decode: a bypassed word is neither stored nor popped.
    always_comb begin
        push = in_valid && in_ready && !bypass;
        pop  = out_valid && out_ready && !empty;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (in_valid && !in_ready);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - scoreboard bench for stream_fifo with T=int, DEPTH=4
module tb_stream_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        afull;
    logic        ovf;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_word;

    stream_fifo #(.T(int), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .afull     (afull),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (afull !== 1'b0) begin miscompares++; $display("FAIL reset_afull: got %b expected 0", afull); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            #1;
            vectors++; if (count !== 3'(i)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
            vectors++; if (afull !== (i >= 3)) begin miscompares++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, afull, (i >= 3)); end
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, in_ready); end
            sb.push_back(vals[i]);
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 32'h55;
        #1;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        vectors++; if (afull !== 1'b1) begin miscompares++; $display("FAIL full_afull: got %b expected 1", afull); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d expected 4", count); end
    endtask

    task automatic test_drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (count !== 3'(4 - i)) begin miscompares++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 4 - i); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_out_valid[%0d]: got %b expected 1", i, out_valid); end
            exp_word = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            vectors++; if (out_data !== exp_word) begin miscompares++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, out_data, exp_word); end
            @(negedge clk);
        end
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty_valid: got %b expected 0", out_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_empty_count: got %0d expected 0", count); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 32'd0; out_ready = 1'b1;
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        // With fall-through the first word leaves immediately.
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'd0) begin miscompares++; $display("FAIL b2b_first_bypass: got %b/%0h expected 1/0", out_valid, out_data); end
`else
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_first_latency: got %b expected 0", out_valid); end
        sb.push_back(32'd0);
`endif
        @(negedge clk);
        for (int k = 1; k < 10; k++) begin
            in_data = 32'(k);
            #1;
`ifndef STREAM_FIFO_BYPASS_EN
            vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d expected 1", k, count); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, out_valid); end
            exp_word = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            vectors++; if (out_data !== exp_word) begin miscompares++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, out_data, exp_word); end
            sb.push_back(32'(k));
`else
            vectors++; if (out_data !== 32'(k)) begin miscompares++; $display("FAIL b2b_bypass_data[%0d]: got %0h expected %0h", k, out_data, k); end
`endif
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
`ifndef STREAM_FIFO_BYPASS_EN
        exp_word = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        vectors++; if (out_data !== exp_word) begin miscompares++; $display("FAIL b2b_last_data: got %0h expected %0h", out_data, exp_word); end
`endif
        @(negedge clk);
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL b2b_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; @(negedge clk);
        in_data = 32'hA2; @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL mid_pre_count: got %0d expected 2", count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf: got %b expected 0", ovf); end
        in_valid = 1'b1; in_data = 32'hAA;
        sb.push_back(32'hAA);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_aa_valid: got %b expected 1", out_valid); end
        exp_word = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        vectors++; if (out_data !== exp_word) begin miscompares++; $display("FAIL mid_aa_data: got %0h expected %0h", out_data, exp_word); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL mid_aa_popped: got %0d expected 0", count); end
    endtask

    task automatic test_empty_input();
        in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
        vectors++; if (out_data !== 32'h5A) begin miscompares++; $display("FAIL bypass_data: got %0h expected 5a", out_data); end
`else
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL no_bypass_valid: got %b expected 0", out_valid); end
`endif
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL empty_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
        vectors++; if (count !== 3'd1 || out_data !== 32'h5A) begin miscompares++; $display("FAIL stored_5a: got %0d/%0h expected 1/5a", count, out_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        test_empty_input();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
